// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg -- shared definitions for the command sequencer.
//   Opcode constants for the broadcast bus, bit positions of the fields in
//   the job commit command, the FSM state type, the captured-job record and
//   two helpers that build the bus words for a job.
package cmd_seq_pkg;

    localparam int CMD_W     = 20;
    localparam int OP_W      = 3;
    localparam int NUM_WORDS = 5;

    localparam logic [OP_W-1:0] OP_INJ0   = 3'd0;
    localparam logic [OP_W-1:0] OP_INJ1   = 3'd1;
    localparam logic [OP_W-1:0] OP_INJ2   = 3'd2;
    localparam logic [OP_W-1:0] OP_INJ3   = 3'd3;
    localparam logic [OP_W-1:0] OP_INJ4   = 3'd4;
    localparam logic [OP_W-1:0] OP_RD5    = 3'd5;
    localparam logic [OP_W-1:0] OP_RD6    = 3'd6;
    localparam logic [OP_W-1:0] OP_COMMIT = 3'd7;

    // Commit command field positions
    localparam int CMT_CYCLE_LSB  = 0;
    localparam int CMT_CYCLE_W    = 5;
    localparam int CMT_INJECT_BIT = 5;
    localparam int CMT_SAMPLE_BIT = 6;
    localparam int CMT_ID_LSB     = 8;
    localparam int CMT_ID_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]   id;
        logic [4:0]   cycle;
        logic         inject;
        logic         sample;
        logic [99:0]  words;
    } job_t;

    // Inject wins when both inject and sample are requested.
    function automatic logic [CMD_W-1:0] commit_cmd(input job_t j);
        logic [CMD_W-1:0] c;
        c = '0;
        c[CMT_CYCLE_LSB +: CMT_CYCLE_W] = j.cycle;
        c[CMT_INJECT_BIT]               = j.inject;
        c[CMT_SAMPLE_BIT]               = j.sample & ~j.inject;
        c[CMT_ID_LSB +: CMT_ID_W]       = j.id;
        return c;
    endfunction

    function automatic logic [CMD_W-1:0] job_word(input job_t j, input logic [2:0] k);
        logic [CMD_W-1:0] w;
        case (k)
            3'd0:    w = j.words[19:0];
            3'd1:    w = j.words[39:20];
            3'd2:    w = j.words[59:40];
            3'd3:    w = j.words[79:60];
            3'd4:    w = j.words[99:80];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cmd_seq.sv
// cmd_seq -- drives the shared command/opcode/async_strobe broadcast bus.
//   Each transfer: load command/opcode, wait SETUP cycles, toggle the strobe,
//   hold HOLD cycles. A job is six chained transfers (inject words 0..4, then
//   the commit) with the next load on the edge the previous HOLD ends.
//   Optional feature: job path compiled only with macro CMD_SEQ_JOB_EN;
//   without it the job ports remain but job_ready/job_done are tied low.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          single command handshake (in_opcode, in_command)
//   job_valid/job_ready        job handshake (job_id, job_cycle, job_inject,
//                              job_sample, job_words = 5 x 20-bit words)
//   command, opcode,
//   async_strobe               registered broadcast bus
//   busy, job_done,
//   strobe_count               status: not idle, job finished pulse, toggles
module cmd_seq
    import cmd_seq_pkg::*;
#(
    parameter int SETUP = 2,
    parameter int HOLD  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_opcode,
    input  logic [19:0]  in_command,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [7:0]   job_id,
    input  logic [4:0]   job_cycle,
    input  logic         job_inject,
    input  logic         job_sample,
    input  logic [99:0]  job_words,
    output logic [19:0]  command,
    output logic [2:0]   opcode,
    output logic         async_strobe,
    output logic         busy,
    output logic         job_done,
    output logic [15:0]  strobe_count
);

    state_t            state;
    logic [7:0]        cnt;       // shared SETUP/HOLD down-counter
    logic [CMD_W-1:0]  pend_cmd;  // transfer waiting to be put on the bus
    logic [OP_W-1:0]   pend_op;

    assign in_ready = rst_n && (state == S_IDLE);
    assign busy     = (state != S_IDLE);

`ifdef CMD_SEQ_JOB_EN
    job_t              job_q;
    logic              job_act;
    logic [2:0]        widx;      // index of the transfer on the bus (5 = commit)
    logic [2:0]        nxt_idx;
    logic [OP_W-1:0]   nxt_op;
    logic [CMD_W-1:0]  nxt_cmd;

    assign job_ready = rst_n && (state == S_IDLE) && !in_valid;

    always_comb begin
        nxt_idx = widx + 3'd1;
        nxt_op  = nxt_idx;
        nxt_cmd = job_word(job_q, nxt_idx);
        if (nxt_idx == 3'd5) begin
            nxt_op  = OP_COMMIT;
            nxt_cmd = commit_cmd(job_q);
        end
    end
`else
    logic unused_job;
    assign unused_job = ^{job_valid, job_id, job_cycle, job_inject, job_sample, job_words};
    assign job_ready  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            command      <= '0;
            opcode       <= OP_RD5;  // a reset glitch on the strobe only hits unused slot 5
            async_strobe <= 1'b0;
            strobe_count <= '0;
            job_done     <= 1'b0;
`ifdef CMD_SEQ_JOB_EN
            job_act      <= 1'b0;
            widx         <= '0;
`endif
        end else begin
            job_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        pend_cmd <= in_command;
                        pend_op  <= in_opcode;
                        cnt      <= 8'(SETUP);
                        state    <= S_SETUP;
                    end
`ifdef CMD_SEQ_JOB_EN
                    else if (job_valid) begin
                        job_q.id     <= job_id;
                        job_q.cycle  <= job_cycle;
                        job_q.inject <= job_inject;
                        job_q.sample <= job_sample;
                        job_q.words  <= job_words;
                        job_act      <= 1'b1;
                        widx         <= '0;
                        pend_cmd     <= job_words[19:0];
                        pend_op      <= OP_INJ0;
                        cnt          <= 8'(SETUP);
                        state        <= S_SETUP;
                    end
`endif
                end

                // Reloading the bus every SETUP cycle is harmless: pend_* is
                // stable, and it makes the first SETUP edge the load edge.
                S_SETUP: begin
                    command <= pend_cmd;
                    opcode  <= pend_op;
                    if (cnt == 8'd1) begin
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                S_STROBE: begin
                    async_strobe <= ~async_strobe;
                    strobe_count <= strobe_count + 16'd1;
                    cnt          <= 8'(HOLD);
                    state        <= S_HOLD;
                end

                S_HOLD: begin
                    if (cnt != 8'd1) begin
                        cnt <= cnt - 8'd1;
                    end else begin
`ifdef CMD_SEQ_JOB_EN
                        if (job_act && (widx != 3'd5)) begin
                            // Chain: this edge is the next transfer's load edge.
                            command  <= nxt_cmd;
                            opcode   <= nxt_op;
                            pend_cmd <= nxt_cmd;
                            pend_op  <= nxt_op;
                            widx     <= nxt_idx;
                            cnt      <= 8'(SETUP - 1);
                            state    <= (SETUP == 1) ? S_STROBE : S_SETUP;
                        end else begin
                            job_done <= job_act;
                            job_act  <= 1'b0;
                            state    <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_seq.sv
module tb_cmd_seq;

    localparam int S = 2;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_opcode;
    logic [19:0]  in_command;
    logic         job_valid;
    logic         job_ready;
    logic [7:0]   job_id;
    logic [4:0]   job_cycle;
    logic         job_inject;
    logic         job_sample;
    logic [99:0]  job_words;
    logic [19:0]  command;
    logic [2:0]   opcode;
    logic         async_strobe;
    logic         busy;
    logic         job_done;
    logic [15:0]  strobe_count;

    always #5 clk = ~clk;

    cmd_seq #(.SETUP(S), .HOLD(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_command(in_command),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_id(job_id), .job_cycle(job_cycle),
        .job_inject(job_inject), .job_sample(job_sample),
        .job_words(job_words),
        .command(command), .opcode(opcode), .async_strobe(async_strobe),
        .busy(busy), .job_done(job_done), .strobe_count(strobe_count)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [19:0] cmd;
        logic [2:0]  exp_op;
        logic [19:0] exp_cmd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    // Called at a negedge with the DUT idle. Accept edge is the next posedge (t).
    task automatic single(input logic [2:0] op, input logic [19:0] cmd,
                          input logic [2:0] eop, input logic [19:0] ecmd,
                          input logic [15:0] ecnt, input string tag);
        logic prev_strobe;
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        prev_strobe = async_strobe;
        in_valid   = 1'b1;
        in_opcode  = op;
        in_command = cmd;
        @(negedge clk);                          // after t
        in_valid   = 1'b0;
        in_opcode  = 3'd0;
        in_command = 20'h0;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);                          // after t+1
        chk({tag, ".opcode"}, {29'd0, opcode}, {29'd0, eop});
        chk({tag, ".command"}, {12'd0, command}, {12'd0, ecmd});
        repeat (S - 1) @(negedge clk);           // after t+S
        chk({tag, ".strobe_early"}, {31'd0, async_strobe}, {31'd0, prev_strobe});
        @(negedge clk);                          // after t+1+S
        chk({tag, ".strobe_toggle"}, {31'd0, async_strobe}, {31'd0, ~prev_strobe});
        chk({tag, ".count"}, {16'd0, strobe_count}, {16'd0, ecnt});
        repeat (H - 1) @(negedge clk);           // after t+S+H
        chk({tag, ".in_ready_hold"}, {31'd0, in_ready}, 32'd0);
        chk({tag, ".command_stable"}, {12'd0, command}, {12'd0, ecmd});
        @(negedge clk);                          // after t+1+S+H
        chk({tag, ".in_ready_done"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    endtask

`ifdef CMD_SEQ_JOB_EN
    // Called at a negedge with the DUT idle; checks every load edge and the
    // job_done pulse, scrambling the job inputs after accept.
    task automatic run_job(input logic [7:0] id, input logic [4:0] cyc,
                           input logic inj, input logic smp,
                           input logic [19:0] w [5], input logic [19:0] ecommit,
                           input logic [15:0] ecnt, input string tag);
        logic [2:0]  eop;
        logic [19:0] ecmd;
        chk({tag, ".job_ready"}, {31'd0, job_ready}, 32'd1);
        job_valid  = 1'b1;
        job_id     = id;
        job_cycle  = cyc;
        job_inject = inj;
        job_sample = smp;
        job_words  = {w[4], w[3], w[2], w[1], w[0]};
        @(negedge clk);                          // after t
        job_valid  = 1'b0;
        job_id     = ~id;
        job_cycle  = ~cyc;
        job_inject = ~inj;
        job_sample = ~smp;
        job_words  = ~job_words;
        for (int c = 1; c <= 62; c++) begin
            @(negedge clk);                      // after t+c
            if (((c - 1) % (S + H)) == 0 && c <= 51) begin
                int k;
                k = (c - 1) / (S + H);
                if (k < 5) begin
                    eop  = 3'(k);
                    ecmd = w[k];
                end else begin
                    eop  = 3'd7;
                    ecmd = ecommit;
                end
                chk($sformatf("%s.op%0d", tag, k), {29'd0, opcode}, {29'd0, eop});
                chk($sformatf("%s.cmd%0d", tag, k), {12'd0, command}, {12'd0, ecmd});
            end
            chk($sformatf("%s.job_done_c%0d", tag, c), {31'd0, job_done}, (c == 61) ? 32'd1 : 32'd0);
        end
        chk({tag, ".count"}, {16'd0, strobe_count}, {16'd0, ecnt});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = 3'd0;
        in_command = 20'h0;
        job_valid  = 1'b0;
        job_id     = 8'h0;
        job_cycle  = 5'd0;
        job_inject = 1'b0;
        job_sample = 1'b0;
        job_words  = 100'h0;

        vecs[0] = '{op: 3'd3, cmd: 20'h12345, exp_op: 3'd3, exp_cmd: 20'h12345, exp_cnt: 16'd1};
        vecs[1] = '{op: 3'd5, cmd: 20'hfffff, exp_op: 3'd5, exp_cmd: 20'hfffff, exp_cnt: 16'd2};
        vecs[2] = '{op: 3'd6, cmd: 20'h0abcd, exp_op: 3'd6, exp_cmd: 20'h0abcd, exp_cnt: 16'd3};
        vecs[3] = '{op: 3'd0, cmd: 20'h80001, exp_op: 3'd0, exp_cmd: 20'h80001, exp_cnt: 16'd4};
        vecs[4] = '{op: 3'd7, cmd: 20'h5a5a5, exp_op: 3'd7, exp_cmd: 20'h5a5a5, exp_cnt: 16'd5};

        // Reset
        @(negedge clk);
        chk("rst.in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("rst.job_ready_low", {31'd0, job_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst.opcode", {29'd0, opcode}, 32'd5);
        chk("rst.command", {12'd0, command}, 32'd0);
        chk("rst.strobe", {31'd0, async_strobe}, 32'd0);
        chk("rst.count", {16'd0, strobe_count}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.job_done", {31'd0, job_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready_after", {31'd0, in_ready}, 32'd1);

        // Single commands, back to back at minimum period
        for (int i = 0; i < 5; i++) begin
            single(vecs[i].op, vecs[i].cmd, vecs[i].exp_op, vecs[i].exp_cmd,
                   vecs[i].exp_cnt, $sformatf("vec%0d", i));
        end

        // Reset during a single command's HOLD phase
        in_valid   = 1'b1;
        in_opcode  = 3'd6;
        in_command = 20'h33333;
        @(negedge clk);                          // after t
        in_valid = 1'b0;
        repeat (5) @(negedge clk);               // after t+5, in HOLD
        chk("rstx.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstx.in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rstx.opcode", {29'd0, opcode}, 32'd5);
        chk("rstx.command", {12'd0, command}, 32'd0);
        chk("rstx.strobe", {31'd0, async_strobe}, 32'd0);
        chk("rstx.count", {16'd0, strobe_count}, 32'd0);
        chk("rstx.busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (S + H + 2) @(negedge clk);
        chk("rstx.no_resume_strobe", {31'd0, async_strobe}, 32'd0);
        chk("rstx.in_ready", {31'd0, in_ready}, 32'd1);

        // strobe_count wrap
        force dut.strobe_count = 16'hffff;
        @(negedge clk);
        release dut.strobe_count;
        @(negedge clk);
        chk("wrap.preload", {16'd0, strobe_count}, 32'h0000ffff);
        single(3'd1, 20'h00f0f, 3'd1, 20'h00f0f, 16'd0, "wrap");

`ifdef CMD_SEQ_JOB_EN
        begin
            logic [19:0] w [5];
            logic        seen;
            // Job with inject and sample both set: inject wins
            w[0] = 20'h11111; w[1] = 20'h22222; w[2] = 20'h33333;
            w[3] = 20'h44444; w[4] = 20'h55555;
            run_job(8'h2a, 5'd17, 1'b1, 1'b1, w, 20'h02a31, 16'd6, "job1");

            // Priority: single command first, job follows
            in_valid   = 1'b1;
            in_opcode  = 3'd5;
            in_command = 20'h11111;
            job_valid  = 1'b1;
            job_id     = 8'h81;
            job_cycle  = 5'd3;
            job_inject = 1'b0;
            job_sample = 1'b1;
            job_words  = {20'h0e0e0, 20'h0d0d0, 20'h0c0c0, 20'h0b0b0, 20'h0a0a0};
            chk("prio.job_ready_low", {31'd0, job_ready}, 32'd0);
            chk("prio.in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);                      // after t
            in_valid = 1'b0;
            @(negedge clk);                      // after t+1
            chk("prio.single_op", {29'd0, opcode}, 32'd5);
            chk("prio.single_cmd", {12'd0, command}, 32'h11111);
            repeat (S + H) @(negedge clk);       // after t+1+S+H
            chk("prio.job_ready_idle", {31'd0, job_ready}, 32'd1);
            @(negedge clk);                      // job accepted
            job_valid = 1'b0;
            chk("prio.job_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("prio.job_op0", {29'd0, opcode}, 32'd0);
            chk("prio.job_cmd0", {12'd0, command}, 32'h0a0a0);
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (job_done) begin
                    seen = 1'b1;
                    chk("prio.commit_cmd", {12'd0, command}, 32'h08143);
                end
            end
            chk("prio.job_done_seen", {31'd0, seen}, 32'd1);
            chk("prio.count", {16'd0, strobe_count}, 32'd13);

            // Reset mid-job during the opcode-2 HOLD phase
            @(negedge clk);
            job_valid  = 1'b1;
            job_id     = 8'h55;
            job_words  = {20'h99999, 20'h88888, 20'h77777, 20'h66666, 20'h12121};
            @(negedge clk);                      // after t
            job_valid = 1'b0;
            repeat (25) @(negedge clk);          // after t+25
            chk("rstjob.op_before", {29'd0, opcode}, 32'd2);
            rst_n = 1'b0;
            @(negedge clk);
            chk("rstjob.opcode", {29'd0, opcode}, 32'd5);
            chk("rstjob.command", {12'd0, command}, 32'd0);
            chk("rstjob.strobe", {31'd0, async_strobe}, 32'd0);
            chk("rstjob.busy", {31'd0, busy}, 32'd0);
            rst_n = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (job_done || async_strobe) seen = 1'b1;
            end
            chk("rstjob.no_done_no_strobe", {31'd0, seen}, 32'd0);
            chk("rstjob.in_ready", {31'd0, in_ready}, 32'd1);
        end
`else
        begin
            logic seen_ready;
            logic [15:0] cnt0;
            cnt0       = strobe_count;
            seen_ready = 1'b0;
            job_valid  = 1'b1;
            job_id     = 8'h2a;
            job_words  = {5{20'habcde}};
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (job_ready || busy || job_done) seen_ready = 1'b1;
            end
            job_valid = 1'b0;
            chk("nojob.no_ready_busy_done", {31'd0, seen_ready}, 32'd0);
            chk("nojob.count", {16'd0, strobe_count}, {16'd0, cnt0});
            chk("nojob.count_abs", {16'd0, strobe_count}, 32'd0);
            single(3'd6, 20'h6a6a6, 3'd6, 20'h6a6a6, 16'd1, "nojob_single");
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
